// File: rtl/spi_master.sv
// SPI initiator: full-duplex DATA_W-bit transfers, all four CPOL/CPHA modes.
// Define SPI_MASTER_LSB_FIRST_EN for LSB-first bit order (default MSB first).
module spi_master #(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              CPOL,
    input  logic              CPHA,
    input  logic              start,
    input  logic [DATA_W-1:0] datain,
    output logic              busy,
    output logic              data_valid,
    output logic [DATA_W-1:0] dataout,
    output logic              sclk,
    output logic              ss,
    output logic              mosi,
    input  logic              miso
);

    localparam int DIV_W  = $clog2(CLK_DIV);
    localparam int EDGE_W = $clog2(2 * DATA_W + 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_W);

    generate
        if (CLK_DIV < 2) begin : g_bad_div
            $error("spi_master: CLK_DIV must be >= 2");
        end
        if (DATA_W < 2) begin : g_bad_width
            $error("spi_master: DATA_W must be >= 2");
        end
    endgenerate

    typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, GAP} state_t;

    state_t              state, state_nx;
    logic [DIV_W-1:0]    div_cnt;
    logic [EDGE_W-1:0]   edge_cnt;
    logic [EDGE_W-1:0]   edge_num;
    logic                cpol_q, cpha_q;
    logic [DATA_W-1:0]   tx_q, rx_q;
    logic                accept, period_end;
    logic                edge_tick, sample_tick, shift_tick;
    logic                ss_d, busy_d, dv_d;

`ifdef SPI_MASTER_LSB_FIRST_EN
    function automatic logic first_bit(input logic [DATA_W-1:0] w);
        return w[0];
    endfunction
    function automatic logic [DATA_W-1:0] tx_shift(input logic [DATA_W-1:0] w);
        return {1'b0, w[DATA_W-1:1]};
    endfunction
    function automatic logic [DATA_W-1:0] rx_shift(input logic [DATA_W-1:0] w,
                                                   input logic b);
        return {b, w[DATA_W-1:1]};
    endfunction
`else
    function automatic logic first_bit(input logic [DATA_W-1:0] w);
        return w[DATA_W-1];
    endfunction
    function automatic logic [DATA_W-1:0] tx_shift(input logic [DATA_W-1:0] w);
        return {w[DATA_W-2:0], 1'b0};
    endfunction
    function automatic logic [DATA_W-1:0] rx_shift(input logic [DATA_W-1:0] w,
                                                   input logic b);
        return {w[DATA_W-2:0], b};
    endfunction
`endif

    // Edge 1 is produced leaving SETUP; XFER counts from edge 2 onward.
    assign accept      = (state == IDLE) && start;
    assign period_end  = (div_cnt == DIV_LAST);
    assign edge_num    = edge_cnt + ((state == XFER) ? EDGE_W'(2) : EDGE_W'(1));
    assign edge_tick   = ((state == SETUP) || (state == XFER)) && period_end;
    assign sample_tick = edge_tick && (edge_num[0] ^ cpha_q);
    assign shift_tick  = edge_tick && !(edge_num[0] ^ cpha_q)
                       && (cpha_q || (edge_num != EDGE_LAST));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            div_cnt  <= '0;
            edge_cnt <= '0;
        end else begin
            state <= state_nx;
            if (state_nx != state) begin
                div_cnt  <= '0;
                edge_cnt <= '0;
            end else if (state != IDLE) begin
                div_cnt <= period_end ? '0 : div_cnt + DIV_W'(1);
                if ((state == XFER) && edge_tick)
                    edge_cnt <= edge_cnt + EDGE_W'(1);
            end
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = SETUP;
            SETUP:   if (period_end) state_nx = XFER;
            XFER:    if (edge_tick && (edge_num == EDGE_LAST)) state_nx = HOLD;
            HOLD:    if (period_end) state_nx = GAP;
            GAP:     if (period_end) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        ss_d   = 1'b1;
        busy_d = 1'b0;
        dv_d   = 1'b0;
        unique case (state)
            IDLE: begin
                ss_d   = !start;
                busy_d = start;
            end
            SETUP, XFER: begin
                ss_d   = 1'b0;
                busy_d = 1'b1;
            end
            HOLD: begin
                ss_d   = period_end;
                busy_d = 1'b1;
                dv_d   = period_end;
            end
            GAP:     busy_d = !period_end;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss         <= 1'b1;
            sclk       <= 1'b0;
            mosi       <= 1'b0;
            busy       <= 1'b0;
            data_valid <= 1'b0;
            dataout    <= '0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            tx_q       <= '0;
            rx_q       <= '0;
        end else begin
            ss         <= ss_d;
            busy       <= busy_d;
            data_valid <= dv_d;
            if (state == IDLE)
                sclk <= CPOL;
            else if (edge_tick)
                sclk <= ~sclk;
            else if (state != XFER)
                sclk <= cpol_q;
            // CPHA=0 presents the first bit before any sclk edge.
            if (accept) begin
                cpol_q <= CPOL;
                cpha_q <= CPHA;
                rx_q   <= '0;
                if (CPHA) begin
                    tx_q <= datain;
                end else begin
                    tx_q <= tx_shift(datain);
                    mosi <= first_bit(datain);
                end
            end else if (shift_tick) begin
                mosi <= first_bit(tx_q);
                tx_q <= tx_shift(tx_q);
            end
            if (sample_tick)
                rx_q <= rx_shift(rx_q, miso);
            if (dv_d)
                dataout <= rx_q;
        end
    end

endmodule
